// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: the four control-token symbols (also used by the
// transmit-side encoder) and the receive alignment FSM state type.
package tmds_pkg;

    // Control tokens, written MSB..LSB; bit 0 is the first bit on the wire.
    // Index order gives the decoded {C1,C0} value.
    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    localparam int SYM_BITS = 10;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } tmds_state_e;

endpackage

// File: rtl/tmds_deserializer_token_match.sv
// Combinational control-token comparator.
// Ports: word[9:0] in; is_token out; idx[1:0] out ({C1,C0} of the token).
module tmds_token_match
    import tmds_pkg::*;
(
    input  logic [9:0] word,
    output logic       is_token,
    output logic [1:0] idx
);

    always_comb begin
        is_token = 1'b1;
        idx      = 2'd0;
        unique case (word)
            TOK_C00: idx = 2'd0;
            TOK_C01: idx = 2'd1;
            TOK_C10: idx = 2'd2;
            TOK_C11: idx = 2'd3;
            default: is_token = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_deserializer.sv
// Single-channel TMDS 1:10 receive deserializer with token-based bitslip
// alignment, all in the bit-rate clock domain.
// Ports: clk_pixel_x10, reset (async, active high), tmds_in (serial, LSB
// first); word[9:0] / word_valid (assembled symbol + strobe), locked,
// slip (bitslip debug pulse).
// Macro TMDS_CTRL_DECODE_EN adds ctrl[1:0] ({C1,C0}) and de outputs,
// registered together with word.
module tmds_deserializer
    import tmds_pkg::*;
#(
    parameter int LOCK_COUNT   = 4,
    parameter int SEARCH_WORDS = 16,
    parameter int LOSS_WORDS   = 2048
) (
    input  logic       clk_pixel_x10,
    input  logic       reset,
    input  logic       tmds_in,
    output logic [9:0] word,
    output logic       word_valid,
    output logic       locked,
    output logic       slip
`ifdef TMDS_CTRL_DECODE_EN
    ,
    output logic [1:0] ctrl,
    output logic       de
`endif
);

    localparam int TOK_W  = $clog2(LOCK_COUNT) + 1;
    localparam int MISS_W = $clog2(SEARCH_WORDS) + 1;
    localparam int GAP_W  = $clog2(LOSS_WORDS) + 1;

    localparam logic [TOK_W-1:0]  LOCK_C   = TOK_W'(LOCK_COUNT);
    localparam logic [MISS_W-1:0] SEARCH_C = MISS_W'(SEARCH_WORDS);
    localparam logic [GAP_W-1:0]  LOSS_C   = GAP_W'(LOSS_WORDS);

    logic [9:0]        sr_q, sr_d;
    logic [3:0]        ph_q, ph_d;
    logic [9:0]        word_q, word_d;
    logic              word_valid_q, word_valid_d;
    logic              tok_q, tok_d;
    logic              locked_q, locked_d;
    logic              slip_q, slip_d;
    tmds_state_e       state_q, state_d;
    logic [TOK_W-1:0]  tok_cnt_q, tok_cnt_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic [GAP_W-1:0]  gap_q, gap_d;

    logic              cap;
    logic              nxt_is_tok;
    logic [1:0]        nxt_idx;
    logic [TOK_W-1:0]  tok_inc;
    logic [MISS_W-1:0] miss_inc;
    logic [GAP_W-1:0]  gap_inc;

    // The comparator looks at the symbol about to be captured so the
    // token flag (and decode) land in the same register stage as word.
    tmds_token_match u_match (
        .word     (sr_d),
        .is_token (nxt_is_tok),
        .idx      (nxt_idx)
    );

    always_comb begin
        sr_d = {tmds_in, sr_q[9:1]};
        // A slip freezes the phase for one cycle, pushing the next
        // word boundary one bit later.
        if (slip_q) begin
            ph_d = ph_q;
        end else if (ph_q == 4'(SYM_BITS - 1)) begin
            ph_d = 4'd0;
        end else begin
            ph_d = ph_q + 4'd1;
        end
        cap          = (ph_q == 4'(SYM_BITS - 1)) && !slip_q;
        word_d       = cap ? sr_d : word_q;
        word_valid_d = cap;
        tok_d        = cap ? nxt_is_tok : tok_q;
    end

    always_comb begin
        tok_inc  = (&tok_cnt_q) ? tok_cnt_q : tok_cnt_q + 1'b1;
        miss_inc = (&miss_q) ? miss_q : miss_q + 1'b1;
        gap_inc  = (&gap_q) ? gap_q : gap_q + 1'b1;

        state_d   = state_q;
        tok_cnt_d = tok_cnt_q;
        miss_d    = miss_q;
        gap_d     = gap_q;
        slip_d    = 1'b0;

        if (word_valid_q) begin
            unique case (state_q)
                ST_SEARCH: begin
                    if (tok_q) begin
                        state_d   = ST_VERIFY;
                        tok_cnt_d = TOK_W'(1);
                        miss_d    = '0;
                    end else if (miss_inc == SEARCH_C) begin
                        slip_d = 1'b1;
                        miss_d = '0;
                    end else begin
                        miss_d = miss_inc;
                    end
                end
                ST_VERIFY: begin
                    if (tok_q) begin
                        tok_cnt_d = tok_inc;
                        if (tok_inc == LOCK_C) begin
                            state_d = ST_LOCKED;
                            gap_d   = '0;
                        end
                    end else begin
                        state_d = ST_SEARCH;
                        slip_d  = 1'b1;
                        miss_d  = '0;
                    end
                end
                ST_LOCKED: begin
                    if (tok_q) begin
                        gap_d = '0;
                    end else begin
                        gap_d = gap_inc;
                        // Lock loss re-enters the hunt without a slip:
                        // the old alignment is the best first guess.
                        if (gap_inc == LOSS_C) begin
                            state_d = ST_SEARCH;
                            miss_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                    miss_d  = '0;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk_pixel_x10 or posedge reset) begin
        if (reset) begin
            sr_q         <= '0;
            ph_q         <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            tok_q        <= 1'b0;
            locked_q     <= 1'b0;
            slip_q       <= 1'b0;
            state_q      <= ST_SEARCH;
            tok_cnt_q    <= '0;
            miss_q       <= '0;
            gap_q        <= '0;
        end else begin
            sr_q         <= sr_d;
            ph_q         <= ph_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            tok_q        <= tok_d;
            locked_q     <= locked_d;
            slip_q       <= slip_d;
            state_q      <= state_d;
            tok_cnt_q    <= tok_cnt_d;
            miss_q       <= miss_d;
            gap_q        <= gap_d;
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign locked     = locked_q;
    assign slip       = slip_q;

    // sr_q[0] is shifted out, never read; it exists so sr matches the
    // symbol width. Without decode, the token index is also unused.
    logic unused_bits;

`ifdef TMDS_CTRL_DECODE_EN
    logic [1:0] ctrl_q, ctrl_d;
    logic       de_q, de_d;

    always_comb begin
        ctrl_d = ctrl_q;
        de_d   = de_q;
        if (cap) begin
            de_d = !nxt_is_tok;
            if (nxt_is_tok) begin
                ctrl_d = nxt_idx;
            end
        end
    end

    always_ff @(posedge clk_pixel_x10 or posedge reset) begin
        if (reset) begin
            ctrl_q <= '0;
            de_q   <= 1'b0;
        end else begin
            ctrl_q <= ctrl_d;
            de_q   <= de_d;
        end
    end

    assign ctrl        = ctrl_q;
    assign de          = de_q;
    assign unused_bits = sr_q[0];
`else
    assign unused_bits = sr_q[0] ^ (^nxt_idx);
`endif

endmodule

// File: tb/tb_tmds_deserializer.sv
// Randomized self-checking bench for tmds_deserializer against a
// word-level behavioural model of the alignment rules.
module tb_tmds_deserializer;

    localparam logic [9:0] T0   = 10'b1101010100;
    localparam logic [9:0] T1   = 10'b0010101011;
    localparam logic [9:0] T2   = 10'b0101010100;
    localparam logic [9:0] T3   = 10'b1010101011;
    localparam logic [9:0] D155 = 10'h155;
    localparam logic [9:0] D2AA = 10'h2AA;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tmds_in = 1'b0;
    logic [9:0] word;
    logic       word_valid, locked, slip;
`ifdef TMDS_CTRL_DECODE_EN
    logic [1:0] ctrl;
    logic       de;
`endif

    tmds_deserializer dut (
        .clk_pixel_x10 (clk),
        .reset         (reset),
        .tmds_in       (tmds_in),
        .word          (word),
        .word_valid    (word_valid),
        .locked        (locked),
        .slip          (slip)
`ifdef TMDS_CTRL_DECODE_EN
        ,
        .ctrl          (ctrl),
        .de            (de)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---- reference model: words are the last ten bits sent -------------
    bit         hist[$];
    int         m_cnt, m_len, m_st, m_miss, m_tc, m_gap;
    bit         p_slip;
    logic [9:0] exp_word;
    logic [1:0] m_ctrl;
    bit         m_de;
    int         slip_seen;

    function automatic int tok_index(logic [9:0] w);
        if (w == T0) return 0;
        if (w == T1) return 1;
        if (w == T2) return 2;
        if (w == T3) return 3;
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_cnt = 0; m_len = 10; m_st = 0;
        m_miss = 0; m_tc = 0; m_gap = 0;
        p_slip = 0; exp_word = '0; m_ctrl = '0; m_de = 0;
    endtask

    // States: 0 search, 1 verify, 2 locked.
    task automatic model_word(logic [9:0] w);
        bit tok;
        tok = (tok_index(w) >= 0);
        if (tok) m_ctrl = 2'(tok_index(w));
        m_de = !tok;
        case (m_st)
            0: if (tok) begin
                   m_st = 1; m_tc = 1; m_miss = 0;
               end else begin
                   m_miss++;
                   if (m_miss == 16) begin p_slip = 1; m_miss = 0; end
               end
            1: if (tok) begin
                   m_tc++;
                   if (m_tc == 4) begin m_st = 2; m_gap = 0; end
               end else begin
                   m_st = 0; p_slip = 1; m_miss = 0;
               end
            default: if (tok) m_gap = 0;
               else begin
                   m_gap++;
                   if (m_gap == 2048) begin m_st = 0; m_miss = 0; end
               end
        endcase
        if (p_slip) m_len = 11;
    endtask

    task automatic step(bit b);
        bit         exp_wv, exp_slip, exp_lock;
        logic [9:0] w;
        tmds_in = b;
        @(posedge clk);
        #1;
        hist.push_back(b);
        if (hist.size() > 10) void'(hist.pop_front());
        exp_slip = p_slip;
        p_slip   = 0;
        exp_lock = (m_st == 2);
        exp_wv   = 0;
        m_cnt++;
        if (m_cnt == m_len) begin
            exp_wv = 1; m_cnt = 0; m_len = 10;
            w = '0;
            for (int i = 0; i < 10; i++) w[i] = hist[i];
            exp_word = w;
            model_word(w);
        end
        check("word_valid", word_valid, exp_wv);
        check("slip", slip, exp_slip);
        check("locked", locked, exp_lock);
        check("word", word, exp_word);
`ifdef TMDS_CTRL_DECODE_EN
        check("ctrl", ctrl, m_ctrl);
        check("de", de, m_de);
`endif
        slip_seen += int'(slip);
    endtask

    // ---- stimulus helpers --------------------------------------------
    logic [9:0] pat;
    int         sp;

    task automatic run(int n);
        for (int i = 0; i < n; i++) begin
            step(pat[sp]);
            sp = (sp + 1) % 10;
        end
    endtask

    // Called at posedge+1; asserts reset mid-cycle and checks that
    // outputs clear before the next clock edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        check("rst_word", word, 10'd0);
        check("rst_word_valid", word_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_slip", slip, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        slip_seen = 0;
    endtask

    task automatic run_rand(int segs);
        logic [9:0] tk[4];
        logic [9:0] w;
        int         mode, n, k;
        tk[0] = T0; tk[1] = T1; tk[2] = T2; tk[3] = T3;
        for (int s = 0; s < segs; s++) begin
            mode = int'($urandom_range(0, 2));
            n    = int'($urandom_range(30, 150));
            k    = int'($urandom_range(0, 9));
            for (int i = 0; i < k; i++) step(1'($urandom));
            w = tk[$urandom_range(0, 3)];
            for (int j = 0; j < n; j++) begin
                if (mode == 1) w = 10'($urandom);
                else if (mode == 2) w = ($urandom_range(0, 1) == 1) ?
                    tk[$urandom_range(0, 3)] : 10'($urandom);
                for (int i = 0; i < 10; i++) step(w[i]);
            end
        end
    endtask

    int s0, budget;

    initial begin
        model_reset();
        slip_seen = 0;
        #1;
        do_reset();

        // Aligned lock: locked one cycle after the 4th word_valid.
        pat = T0; sp = 0;
        run(40);
        check("aligned_prelock", locked, 0);
        run(1);
        check("aligned_lock", locked, 1);
        check("aligned_noslip", slip_seen, 0);
        run(9);
        check("aligned_word", word, 10'(T0));

        // Misaligned: stream enters three bits into the token.
        do_reset();
        pat = T0; sp = 3;
        budget = 0;
        while (!locked && budget < 3000) begin
            run(1);
            budget++;
        end
        check("mis_lock", locked, 1);
        check("mis_slips", slip_seen, 7);
        check("mis_word", word, 10'(T0));

        // Verify abort: two tokens then data.
        do_reset();
        pat = T0; sp = 0;
        run(20);
        pat = D155; sp = 0;
        run(11);
        check("abort_slip", slip, 1);
        check("abort_locked", locked, 0);
        run(30);
        check("abort_slips", slip_seen, 1);

        // Loss of lock.
        do_reset();
        pat = T0; sp = 0;
        run(50);
        pat = D155;
        run(2047 * 10);
        pat = T0;
        run(11);
        check("loss_hold", locked, 1);
        run(9);
        s0 = slip_seen;
        pat = D155;
        run(2048 * 10);
        check("loss_last_wv", locked, 1);
        run(1);
        check("loss_fall", locked, 0);
        run(9);
        check("loss_noslip", slip_seen, s0);

        // Async reset while locked, mid-word, then relock.
        do_reset();
        pat = T0; sp = 0;
        run(54);
        check("pre_rst_locked", locked, 1);
        do_reset();
        sp = 0;
        run(40);
        check("relock_pre", locked, 0);
        run(1);
        check("relock", locked, 1);
        run(9);

`ifdef TMDS_CTRL_DECODE_EN
        pat = T1; sp = 0;
        run(10);
        check("dec_t1_ctrl", ctrl, 2'b01);
        check("dec_t1_de", de, 0);
        pat = T3;
        run(10);
        check("dec_t3_ctrl", ctrl, 2'b11);
        check("dec_t3_de", de, 0);
        pat = D2AA;
        run(10);
        check("dec_data_ctrl", ctrl, 2'b11);
        check("dec_data_de", de, 1);
`endif

        // Randomized streams against the model.
        do_reset();
        run_rand(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
